byte_serial_adder_ctrl: RTL
===========================

// Module: byte_serial_adder_ctrl
// PURPOSE
//   Multi-cycle controller that adds two NBYTES-wide operands byte by byte through the 8-bit ripple-carry adder.
//   Sits directly upstream and downstream of the adder:
//   - drives the adder's A, B and cin from latched operand slices;
//   - captures the adder's S and cout each cycle;
//   - assembles the full-width sum and final carry-out.
// PARAMETERS
//   NBYTES   4   operand width in bytes (>=1); operand width W = 8*NBYTES
// PORTS
//   clk       in   1     system clock, rising edge
//   rst       in   1     asynchronous reset, active-high
//   start     in   1     request; sampled only when busy=0
//   a_in      in   W     operand A, latched on accepted start
//   b_in      in   W     operand B, latched on accepted start
//   cin       in   1     carry-in for byte 0, latched on accepted start
//   busy      out  1     high while in RUN
//   done      out  1     one-cycle pulse: result valid
//   sum_out   out  W     assembled sum; held from done until next accepted start
//   cout_out  out  1     carry-out of top byte; held like sum_out
//   add_a     out  8     to adder A
//   add_b     out  8     to adder B
//   add_cin   out  1     to adder cin
//   add_s     in   8     from adder S
//   add_cout  in   1     from adder cout
// BEHAVIOUR
//   - Reset (async, rst=1): state=IDLE, byte index=0, carry reg=0, operand regs=0.
//     All outputs 0: busy, done, sum_out, cout_out, add_a, add_b, add_cin.
//   - FSM states: IDLE, RUN, DONE.
//     - IDLE: start=1 -> latch a_in, b_in, cin; idx<=0; -> RUN.
//     - RUN: on each edge, sum byte[idx]<=add_s, carry<=add_cout, idx<=idx+1.
//       After idx=NBYTES-1 is captured, go to DONE and set cout_out<=add_cout.
//     - DONE: done=1 for exactly this one cycle.
//       start=1 -> reload operands, -> RUN (back-to-back); otherwise -> IDLE.
//   - Adder drive: combinational from registers.
//     - In RUN: add_a=A[8*idx+:8], add_b=B[8*idx+:8], add_cin=carry reg (byte 0 uses latched cin).
//     - Outside RUN: all three are 0.
//   - Latency: start sampled at edge E -> done high during the cycle after edge E+NBYTES.
//     Throughput is one operation per NBYTES+1 cycles.
//   - start while busy=1 is ignored; operands are not re-sampled.
//   - sum_out/cout_out change only on DONE entry. Not cleared by IDLE; cleared only by rst.
//   - idx width = max(1,$clog2(NBYTES)); no wrap beyond NBYTES-1. NBYTES=1 gives a single RUN cycle.
//   - rst mid-RUN aborts immediately: no done pulse, sum_out/cout_out return to 0.
//   - Arithmetic: {cout_out,sum_out} = a_in + b_in + cin, modulo 2^(W+1). Purely unsigned.
// CONFIGURATION
//   SUBTRACT_EN defined:
//     - Adds port: sub  in  1, latched with the operands on an accepted start.
//     - sub=1: add_b = ~B byte, initial carry forced to 1 (cin ignored).
//       Result = A - B (two's complement); cout_out=1 means no borrow.
//     - sub=0: identical to the undefined case.
//   SUBTRACT_EN undefined: no sub port; addition only.
// TESTING (NBYTES=4)
//   1. a=0x000000FF, b=0x00000001, cin=0
//      -> sum_out=0x00000100, cout_out=0; done 4 edges after start edge, width 1 cycle.
//   2. a=0xFFFFFFFF, b=0x00000001, cin=0
//      -> sum_out=0x00000000, cout_out=1 (carry ripples through all 4 bytes).
//   3. a=0x12345678, b=0x11111111, cin=1 -> sum_out=0x2345678A, cout_out=0.
//      Check add_a sequence 0x78,0x56,0x34,0x12 on consecutive RUN cycles.
//   4. a) start pulsed again on the 2nd RUN cycle with different operands
//         -> ignored; result still matches the first operands.
//      b) Then rst asserted on a 2nd RUN cycle
//         -> busy=0, done never pulses, sum_out=0, cout_out=0.
//   5. start held high through DONE
//      -> second operation begins with no IDLE gap; second done 5 cycles after the first.
//   6. SUBTRACT_EN, sub=1, a=0x00000005, b=0x00000007 -> sum_out=0xFFFFFFFE, cout_out=0.
//      Same with a=7, b=5 -> sum_out=0x00000002, cout_out=1.

Source files
------------

// File: rtl/byte_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : byte_serial_adder_ctrl
//  Description : Multi-cycle controller that adds two NBYTES-wide operands one
//                byte per cycle through an external 8-bit ripple-carry adder.
//                It drives the adder from latched operand slices, captures
//                S/cout each cycle and assembles the full-width result.
//                Optional macro SUBTRACT_EN adds a 'sub' port: when latched
//                high, B is inverted and the initial carry is forced to 1, so
//                the result is A - B (cout_out=1 means no borrow).
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_serial_adder_ctrl #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [8*NBYTES-1:0]   a_in,
    input  logic [8*NBYTES-1:0]   b_in,
    input  logic                  cin,
`ifdef SUBTRACT_EN
    input  logic                  sub,
`endif
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   sum_out,
    output logic                  cout_out,
    output logic [7:0]            add_a,
    output logic [7:0]            add_b,
    output logic                  add_cin,
    input  logic [7:0]            add_s,
    input  logic                  add_cout
);

    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic                    carry_q, carry_d;
    logic [NBYTES-1:0][7:0]  a_q, a_d;
    logic [NBYTES-1:0][7:0]  b_q, b_d;
    logic [NBYTES-1:0][7:0]  acc_q, acc_d;   // bytes collected during RUN
    logic [NBYTES-1:0][7:0]  sum_q, sum_d;   // published result, updated on DONE entry
    logic                    cout_q, cout_d;
    logic                    w_load;
    logic                    w_sub_req;      // subtract request seen on the start cycle
    logic                    w_sub_act;      // subtract mode of the operation in flight

`ifdef SUBTRACT_EN
    logic                    sub_q, sub_d;
    assign w_sub_req = sub;
    assign w_sub_act = sub_q;
`else
    assign w_sub_req = 1'b0;
    assign w_sub_act = 1'b0;
`endif

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef SUBTRACT_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef SUBTRACT_EN
            sub_q   <= sub_d;
`endif
        end
    end

    // Next-state logic: byte capture in RUN, operand load from IDLE or DONE.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        w_load  = 1'b0;
`ifdef SUBTRACT_EN
        sub_d   = sub_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) w_load = 1'b1;
            end
            RUN: begin
                acc_d[idx_q] = add_s;
                carry_d      = add_cout;
                if (idx_q == LAST_IDX) begin
                    // Publish the complete word only once the top byte is in.
                    sum_d   = acc_d;
                    cout_d  = add_cout;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (start) w_load  = 1'b1;
                else       state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (w_load) begin
            a_d     = a_in;
            b_d     = b_in;
            // Subtraction supplies the +1 of the two's complement via carry-in.
            carry_d = w_sub_req ? 1'b1 : cin;
            idx_d   = '0;
            state_d = RUN;
`ifdef SUBTRACT_EN
            sub_d   = sub;
`endif
        end
    end

    // Adder drive: current operand slices and running carry, idle at zero.
    always_comb begin
        add_a   = 8'h00;
        add_b   = 8'h00;
        add_cin = 1'b0;
        if (state_q == RUN) begin
            add_a   = a_q[idx_q];
            add_b   = b_q[idx_q] ^ {8{w_sub_act}};
            add_cin = carry_q;
        end
    end

    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign sum_out  = sum_q;
    assign cout_out = cout_q;

endmodule
`default_nettype wire
